led_data_top: RTL and testbench

Top-level serial writer for an 8-position LED display bank. A parallel byte and a 3-bit target address are captured on a write request. The byte is then shifted out MSB-first on a shared serial data/clock pair while the addressed position's active-low chip select is held asserted. An active-low clear input is forwarded to the display bank.

---
 rtl/led_data_top.sv | 238 +++++++++++++++++++++++
 tb/tb_led_data_top.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_data_top.sv
// led_data_top
// ------------------------------------------------------------------------------
// Serial writer for an 8-position LED display bank.
//
// A write request captures a parallel byte and a 3-bit position address. The
// byte is then shifted out MSB-first on a shared DINex/SCLK pair. While it is
// shifted, the addressed position's active-low chip select is held low. The
// active-low clear request is forwarded to the display bank through one
// register.
//
// Optional feature, selected by the macro INPUT_SYNC_EN:
//   defined   : WRITEIn and CLEARIn each pass through a 2-flop synchronizer
//               before any logic uses them. Every trigger and clear latency
//               grows by 2 cycles.
//   undefined : WRITEIn and CLEARIn are used directly.
//
// Parameters
//   SCLK_HALF  SysClk cycles per SCLK half-period (must be >= 2).
//              SCLK = SysClk / (2 * SCLK_HALF).
//
// Ports
//   SysClk     in   system clock
//   SysRst     in   asynchronous active-high reset
//   DataIn     in   [7:0] byte to transmit, captured at an accepted trigger
//   AddressIn  in   [3:0] target position; 0..7 valid, 8..15 rejected
//   WRITEIn    in   write request; its rising edge triggers a transfer
//   CLEARIn    in   active-low clear; low during a transfer aborts it
//   CLROut     out  active-low clear to the display bank (registered CLEARIn)
//   CSOut      out  [7:0] active-low chip selects, one-hot-low while busy
//   DINex      out  serial data, MSB first, stable around each SCLK rise
//   SCLK       out  serial clock, idle low; the display samples on the rise
//   dbg_state  out  [1:0] current FSM state (IDLE/SETUP/SHIFT/HOLD)
//
// Request semantics
//   WRITEIn is a request with no ready/acknowledge path. A rising edge is
//   taken only when all three hold: the FSM is IDLE, AddressIn[3] is 0, and
//   the clear input is high. Any other rising edge is discarded. Rejected or
//   discarded edges are not queued and do not disturb a transfer in flight.
//   Holding WRITEIn high does not retrigger.
//
// Output timing
//   All serial outputs are registered. They reflect the state held *before*
//   the clock edge that updates them. As a result, CSOut falls one cycle after
//   the accepting edge, and the whole transfer keeps CS low for 18*SCLK_HALF
//   cycles. An abort bypasses this lag: outputs return to idle on the same
//   edge that samples CLEARIn low.
// ------------------------------------------------------------------------------
module led_data_top #(
  parameter int SCLK_HALF = 4
) (
  input  logic       SysClk,
  input  logic       SysRst,
  input  logic [7:0] DataIn,
  input  logic [3:0] AddressIn,
  input  logic       WRITEIn,
  input  logic       CLEARIn,
  output logic       CLROut,
  output logic [7:0] CSOut,
  output logic       DINex,
  output logic       SCLK,
  output logic [1:0] dbg_state
);

  // FSM encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  // Phase counter: it must be able to count one full SCLK period
  // (2 * SCLK_HALF cycles).
  localparam int CW = $clog2(2 * SCLK_HALF) + 1;
  localparam logic [CW-1:0] HALF      = CW'(SCLK_HALF);
  localparam logic [CW-1:0] HALF_LAST = CW'(SCLK_HALF - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(2 * SCLK_HALF - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitcnt;
  logic [7:0]    sr;
  logic [2:0]    addr_q;
  logic          write_s;
  logic          clear_s;
  logic          write_q;
  logic          trig;
  logic          accept;
  logic          abort;
  logic [7:0]    cs_sel;

  // ----------------------------------------------------------------------------
  // Input conditioning
  // ----------------------------------------------------------------------------
`ifdef INPUT_SYNC_EN
  logic [1:0] write_sync;
  logic [1:0] clear_sync;

  // Reset values keep the synchronized lines inactive:
  // no write request, and clear deasserted.
  always_ff @(posedge SysClk or posedge SysRst) begin
    if (SysRst) begin
      write_sync <= 2'b00;
      clear_sync <= 2'b11;
    end else begin
      write_sync <= {write_sync[0], WRITEIn};
      clear_sync <= {clear_sync[0], CLEARIn};
    end
  end

  assign write_s = write_sync[1];
  assign clear_s = clear_sync[1];
`else
  assign write_s = WRITEIn;
  assign clear_s = CLEARIn;
`endif

  // ----------------------------------------------------------------------------
  // Edge detect and clear forwarding
  // ----------------------------------------------------------------------------
  // write_q resets to 0, so WRITEIn already high when reset is released still
  // produces exactly one trigger.
  always_ff @(posedge SysClk or posedge SysRst) begin
    if (SysRst) begin
      write_q <= 1'b0;
      CLROut  <= 1'b0;
    end else begin
      write_q <= write_s;
      CLROut  <= clear_s;
    end
  end

  assign trig   = write_s & ~write_q;
  assign accept = trig & (state == IDLE) & ~AddressIn[3] & clear_s;
  assign abort  = ~clear_s & (state != IDLE);

  // One-hot-low chip select for the latched position
  always_comb begin
    cs_sel         = 8'hFF;
    cs_sel[addr_q] = 1'b0;
  end

  // ----------------------------------------------------------------------------
  // Transfer FSM with registered serial outputs
  // ----------------------------------------------------------------------------
  // SETUP : SCLK_HALF cycles with CS low, bit 7 on DINex, SCLK low.
  // SHIFT : 8 bits, each 2*SCLK_HALF cycles (high half first). DINex advances
  //         on each high-to-low SCLK transition.
  // HOLD  : SCLK_HALF cycles with CS still low after the last bit.
  always_ff @(posedge SysClk or posedge SysRst) begin
    if (SysRst) begin
      state  <= IDLE;
      cnt    <= '0;
      bitcnt <= 3'd0;
      sr     <= 8'h00;
      addr_q <= 3'd0;
      CSOut  <= 8'hFF;
      SCLK   <= 1'b0;
      DINex  <= 1'b0;
    end else if (abort) begin
      state  <= IDLE;
      cnt    <= '0;
      bitcnt <= 3'd0;
      CSOut  <= 8'hFF;
      SCLK   <= 1'b0;
      DINex  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          CSOut <= 8'hFF;
          SCLK  <= 1'b0;
          DINex <= 1'b0;
          if (accept) begin
            sr     <= DataIn;
            addr_q <= AddressIn[2:0];
            cnt    <= '0;
            state  <= SETUP;
          end
        end

        SETUP: begin
          CSOut <= cs_sel;
          SCLK  <= 1'b0;
          DINex <= sr[7];
          if (cnt == HALF_LAST) begin
            cnt    <= '0;
            bitcnt <= 3'd7;
            state  <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SHIFT: begin
          CSOut <= cs_sel;
          SCLK  <= (cnt < HALF);
          // The falling edge of SCLK moves DINex to the next bit. Zeros are
          // shifted in, so DINex drops to 0 once bit 0 has been sent.
          if (cnt == HALF) begin
            DINex <= sr[6];
            sr    <= {sr[6:0], 1'b0};
          end
          if (cnt == FULL_LAST) begin
            cnt <= '0;
            if (bitcnt == 3'd0) begin
              state <= HOLD;
            end else begin
              bitcnt <= bitcnt - 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HOLD: begin
          CSOut <= cs_sel;
          SCLK  <= 1'b0;
          DINex <= 1'b0;
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          CSOut <= 8'hFF;
          SCLK  <= 1'b0;
          DINex <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_led_data_top.sv
// tb_led_data_top
// ------------------------------------------------------------------------------
// Directed testbench for led_data_top with the default SCLK_HALF = 4 and
// INPUT_SYNC_EN undefined.
//
// A negedge monitor keeps running totals:
//   - number of SCLK rises,
//   - the last 8 DINex bits seen at those rises,
//   - CSOut at the most recent rise,
//   - number of cycles with any chip select low.
// Each step compares deltas of these totals against hand-derived values.
// Expected bytes are queued in exp_q.
// ------------------------------------------------------------------------------
module tb_led_data_top;

  localparam int H = 4;

  // ----------------------------------------------------------------------------
  // Clock / reset / DUT
  // ----------------------------------------------------------------------------
  logic       SysClk = 1'b0;
  logic       SysRst;
  logic [7:0] DataIn;
  logic [3:0] AddressIn;
  logic       WRITEIn;
  logic       CLEARIn;
  logic       CLROut;
  logic [7:0] CSOut;
  logic       DINex;
  logic       SCLK;
  logic [1:0] dbg_state;

  always #10 SysClk = ~SysClk;

  led_data_top #(.SCLK_HALF(H)) dut (
    .SysClk    (SysClk),
    .SysRst    (SysRst),
    .DataIn    (DataIn),
    .AddressIn (AddressIn),
    .WRITEIn   (WRITEIn),
    .CLEARIn   (CLEARIn),
    .CLROut    (CLROut),
    .CSOut     (CSOut),
    .DINex     (DINex),
    .SCLK      (SCLK),
    .dbg_state (dbg_state)
  );

  // ----------------------------------------------------------------------------
  // Monitor (running totals, never cleared)
  // ----------------------------------------------------------------------------
  int         rises      = 0;
  int         cs_low     = 0;
  logic [7:0] got        = 8'h00;
  logic [7:0] cs_at_rise = 8'hFF;
  logic       sclk_prev  = 1'b0;

  always @(negedge SysClk) begin
    if (SCLK && !sclk_prev) begin
      rises      = rises + 1;
      got        = {got[6:0], DINex};
      cs_at_rise = CSOut;
    end
    if (CSOut != 8'hFF) cs_low = cs_low + 1;
    sclk_prev = SCLK;
  end

  // ----------------------------------------------------------------------------
  // Scoreboard
  // ----------------------------------------------------------------------------
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         base_r;
  int         base_cs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ----------------------------------------------------------------------------
  // Driver tasks
  // ----------------------------------------------------------------------------
  // Advance n clocks; return 1 time unit after a negedge, clear of both the
  // active edge and the monitor's sampling point.
  task automatic cycles(input int n);
    repeat (n) @(negedge SysClk);
    #1;
  endtask

  task automatic write_pulse(input logic [7:0] d, input logic [3:0] a, input int len);
    DataIn    = d;
    AddressIn = a;
    WRITEIn   = 1'b1;
    cycles(len);
    WRITEIn   = 1'b0;
  endtask

  task automatic mark();
    base_r  = rises;
    base_cs = cs_low;
  endtask

  task automatic check_xfer(input string tag, input logic [7:0] exp_cs);
    logic [7:0] exp_byte;
    exp_byte = exp_q.pop_front();
    chk({tag, "_rises"},  rises - base_r, 8);
    chk({tag, "_byte"},   got, exp_byte);
    chk({tag, "_cs_len"}, cs_low - base_cs, 18 * H);
    chk({tag, "_cs_val"}, cs_at_rise, exp_cs);
  endtask

  // ----------------------------------------------------------------------------
  // Directed sequence
  // ----------------------------------------------------------------------------
  initial begin
    SysRst    = 1'b1;
    DataIn    = 8'h00;
    AddressIn = 4'h0;
    WRITEIn   = 1'b0;
    CLEARIn   = 1'b1;

    // Reset state
    cycles(3);
    chk("rst_cs",    CSOut, 8'hFF);
    chk("rst_sclk",  SCLK, 1'b0);
    chk("rst_din",   DINex, 1'b0);
    chk("rst_clr",   CLROut, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    SysRst = 1'b0;
    cycles(1);
    chk("clr_release", CLROut, 1'b1);
    cycles(2);

    // Write C3 to position 7, with WRITEIn held high for 10 cycles.
    // The edge is sampled at edge k.
    mark();
    exp_q.push_back(8'hC3);
    DataIn    = 8'hC3;
    AddressIn = 4'h7;
    WRITEIn   = 1'b1;
    cycles(1);                          // after k
    chk("lat_cs_k", CSOut, 8'hFF);
    cycles(1);                          // after k+1
    chk("lat_cs_k1",   CSOut, 8'h7F);
    chk("lat_din_k1",  DINex, 1'b1);
    chk("lat_sclk_k1", SCLK, 1'b0);
    cycles(3);                          // after k+4
    chk("lat_sclk_k4", SCLK, 1'b0);
    cycles(1);                          // after k+5: first SCLK rise
    chk("lat_sclk_k5", SCLK, 1'b1);
    cycles(4);
    WRITEIn = 1'b0;
    cycles(90);
    check_xfer("w_c3", 8'h7F);

    // Write 35 to position 2
    mark();
    exp_q.push_back(8'h35);
    write_pulse(8'h35, 4'h2, 3);
    cycles(90);
    check_xfer("w_35", 8'hFB);

    // Bus activity with WRITEIn low must not start anything
    mark();
    DataIn = 8'hAA; AddressIn = 4'h1; cycles(5);
    DataIn = 8'h0F; AddressIn = 4'h5; cycles(5);
    DataIn = 8'hFF; AddressIn = 4'h0; cycles(5);
    chk("quiet_rises", rises - base_r, 0);
    chk("quiet_cs",    cs_low - base_cs, 0);

    // Invalid address is rejected
    mark();
    write_pulse(8'hA5, 4'hF, 3);
    cycles(90);
    chk("badaddr_rises", rises - base_r, 0);
    chk("badaddr_cs",    cs_low - base_cs, 0);
    chk("badaddr_state", dbg_state, 2'd0);

    // A second write edge during a transfer is ignored
    mark();
    exp_q.push_back(8'hA5);
    write_pulse(8'hA5, 4'h4, 3);
    cycles(20);
    write_pulse(8'h00, 4'h1, 3);
    cycles(80);
    check_xfer("w_busy", 8'hEF);

    // Abort with CLEARIn low after bit 3 (5 rises: bits 7..3)
    mark();
    write_pulse(8'h5A, 4'h0, 2);
    for (int i = 0; i < 300; i++) begin
      if (rises - base_r >= 5) break;
      cycles(1);
    end
    chk("abort_reach", rises - base_r, 5);
    CLEARIn = 1'b0;
    cycles(1);
    chk("abort_clr",  CLROut, 1'b0);
    chk("abort_cs",   CSOut, 8'hFF);
    chk("abort_sclk", SCLK, 1'b0);
    chk("abort_din",  DINex, 1'b0);
    cycles(100);
    chk("abort_rises", rises - base_r, 5);
    CLEARIn = 1'b1;
    cycles(1);
    chk("abort_clr_back", CLROut, 1'b1);

    // Normal write after an abort
    mark();
    exp_q.push_back(8'h81);
    write_pulse(8'h81, 4'h3, 2);
    cycles(90);
    check_xfer("w_81", 8'hF7);

    // Reset mid-transfer forces idle outputs asynchronously
    write_pulse(8'hFF, 4'h5, 2);
    cycles(20);
    SysRst = 1'b1;
    #2;
    chk("arst_cs",   CSOut, 8'hFF);
    chk("arst_sclk", SCLK, 1'b0);
    chk("arst_clr",  CLROut, 1'b0);
    cycles(3);
    SysRst = 1'b0;
    cycles(1);
    chk("arst_release_clr", CLROut, 1'b1);
    chk("arst_state",       dbg_state, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
